// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, issue-controller states, flag bit positions
// and opcode classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDS = 4'b0010;
    localparam logic [3:0] OP_SUBS = 4'b0011;
    localparam logic [3:0] OP_CMP  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_MVN  = 4'b1010;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_CMP,
            OP_AND, OP_OR, OP_XOR, OP_MVN: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Opcodes whose flags are architecturally visible in the status register.
    function automatic logic is_flag_op(input logic [3:0] op);
        return (op == OP_ADDS) || (op == OP_SUBS) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first asserted
// request found after rr_ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Round-robin issue controller sharing one combinational ALU between NUM_REQ
// requesters. Optional status-flag register enabled by `define ALU_FLAG_REG_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [4*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [3:0]                alu_control,
    output logic [DATA_W-1:0]         operand_a,
    output logic [DATA_W-1:0]         operand_b,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic [3:0]                alu_flags,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [3:0]                rsp_flags,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [3:0]                cpsr_flags
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic                op_legal;
    logic [ID_W-1:0]     sel_id;
    logic [3:0]          sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .en     (state == IDLE),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign op_legal  = is_legal_op(alu_control);
    assign busy      = (state == EXEC) || (state == RESP);

    always_comb begin
        sel_id = '0;
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_id = ID_W'(i);
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU input registers only move on accept so the ALU sees stable operands
    // through EXEC and between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            alu_control <= '0;
            operand_a   <= '0;
            operand_b   <= '0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_control <= sel_op;
                        operand_a   <= sel_a;
                        operand_b   <= sel_b;
                        rsp_id      <= sel_id;
                        rr_ptr      <= sel_id;
                    end
                end
                EXEC: begin
                    rsp_result <= op_legal ? alu_result : '0;
                    rsp_flags  <= op_legal ? alu_flags  : '0;
                    rsp_err    <= !op_legal;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAG_REG_EN
    logic [3:0] cpsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr_q <= '0;
        end else if (state == EXEC && op_legal && is_flag_op(alu_control)) begin
            cpsr_q <= alu_flags;
        end
    end

    assign cpsr_flags = cpsr_q;
`else
    assign cpsr_flags = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the issue ports.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  cpsr_flags;

    int n_pass  = 0;
    int n_total = 0;

    alu_issue_ctrl #(
        .NUM_REQ (2),
        .ID_W    (1),
        .DATA_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .cpsr_flags  (cpsr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU; illegal opcodes return junk so zeroing is observable.
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        s = '0;
        case (op)
            4'b0000, 4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0001, 4'b0011, 4'b0100: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = a & b;
            4'b1000: r = a | b;
            4'b1001: r = a ^ b;
            4'b1010: r = ~b;
            default: return {4'hF, 32'hDEADBEEF};
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_control, operand_a, operand_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[4*r +: 4]  = op;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int          r;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    vec_t       vecs[12];
    logic [3:0] exp_cpsr;

    initial begin
        vecs[0]  = '{0, 4'b0000, 32'd5,        32'd7,     32'd12,        4'b0000, 1'b0};
        vecs[1]  = '{1, 4'b0011, 32'd3,        32'd3,     32'd0,         4'b0110, 1'b0};
        vecs[2]  = '{0, 4'b0111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 1'b0};
        vecs[3]  = '{1, 4'b0000, 32'hFFFFFFFF, 32'd1,     32'd0,         4'b0110, 1'b0};
        vecs[4]  = '{0, 4'b0001, 32'd1,        32'd2,     32'hFFFFFFFF,  4'b1000, 1'b0};
        vecs[5]  = '{1, 4'b1000, 32'd1,        32'd2,     32'd3,         4'b0000, 1'b0};
        vecs[6]  = '{0, 4'b1001, 32'h000000FF, 32'h0000000F, 32'h000000F0, 4'b0000, 1'b0};
        vecs[7]  = '{1, 4'b1010, 32'd0,        32'd0,     32'hFFFFFFFF,  4'b1000, 1'b0};
        vecs[8]  = '{0, 4'b0010, 32'h7FFFFFFF, 32'd1,     32'h80000000,  4'b1001, 1'b0};
        vecs[9]  = '{1, 4'b1100, 32'd1,        32'd1,     32'd0,         4'b0000, 1'b1};
        vecs[10] = '{0, 4'b0101, 32'd2,        32'd3,     32'd0,         4'b0000, 1'b1};
        vecs[11] = '{1, 4'b0100, 32'd5,        32'd3,     32'd2,         4'b0010, 1'b0};
        exp_cpsr = 4'b0000;

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_operand_a", operand_a, 0);
        check("rst_operand_b", operand_b, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_cpsr", cpsr_flags, 0);

        // Contention: both requesters held valid; rr_ptr starts at 1 so 0 wins first.
        set_req(0, 4'b0000, 32'd1, 32'd2);
        set_req(1, 4'b0001, 32'd10, 32'd4);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_grant", req_ready, (i % 2 == 0) ? 32'd1 : 32'd2);
            cycle();
            check("cont_alu_control", alu_control, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("cont_req_ready_exec", req_ready, 0);
            cycle();
            check("cont_rsp_id", rsp_id, i % 2);
            check("cont_rsp_result", rsp_result, (i % 2 == 0) ? 32'd3 : 32'd6);
            cycle();
        end
        req_valid = '0;

        // Backpressure: response held while the consumer stalls, req1 waits.
        rsp_ready = 1'b0;
        set_req(0, 4'b0000, 32'd5, 32'd7);
        req_valid = 2'b01;
        cycle();
        set_req(1, 4'b1001, 32'd3, 32'd5);
        req_valid = 2'b10;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_result", rsp_result, 12);
            check("bp_rsp_id", rsp_id, 0);
            check("bp_rsp_flags", rsp_flags, 0);
            check("bp_req_ready", req_ready, 0);
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", req_ready, 0);
        cycle();
        check("bp_idle_rsp_valid", rsp_valid, 0);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_grant", req_ready, 2);
        cycle();
        req_valid = '0;
        check("bp_next_alu_control", alu_control, 4'b1001);
        check("bp_next_busy", busy, 1);
        cycle();
        check("bp_next_result", rsp_result, 6);
        check("bp_next_id", rsp_id, 1);
        cycle();
        check("bp_done_rsp_valid", rsp_valid, 0);

        foreach (vecs[k]) begin
            set_req(vecs[k].r, vecs[k].op, vecs[k].a, vecs[k].b);
            req_valid = 2'b00;
            req_valid[vecs[k].r] = 1'b1;
            #1;
            check("vec_grant", req_ready, 32'd1 << vecs[k].r);
            check("vec_idle_busy", busy, 0);
            cycle();
            req_valid = '0;
            check("vec_alu_control", alu_control, vecs[k].op);
            check("vec_operand_a", operand_a, vecs[k].a);
            check("vec_operand_b", operand_b, vecs[k].b);
            check("vec_exec_rsp_valid", rsp_valid, 0);
            cycle();
`ifdef ALU_FLAG_REG_EN
            if (!vecs[k].err && (vecs[k].op == 4'b0010 || vecs[k].op == 4'b0011 ||
                                 vecs[k].op == 4'b0100))
                exp_cpsr = vecs[k].flg;
`endif
            check("vec_rsp_valid", rsp_valid, 1);
            check("vec_rsp_id", rsp_id, vecs[k].r);
            check("vec_rsp_result", rsp_result, vecs[k].res);
            check("vec_rsp_flags", rsp_flags, vecs[k].flg);
            check("vec_rsp_err", rsp_err, vecs[k].err);
            check("vec_cpsr", cpsr_flags, exp_cpsr);
            cycle();
            check("vec_done_rsp_valid", rsp_valid, 0);
        end

        // Reset while the operation is in EXEC: it must vanish without a response.
        set_req(1, 4'b0001, 32'd9, 32'd1);
        req_valid = 2'b10;
        cycle();
        req_valid = '0;
        check("mid_exec_busy", busy, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_alu_control", alu_control, 0);
        check("mid_operand_a", operand_a, 0);
        check("mid_operand_b", operand_b, 0);
        check("mid_rsp_result", rsp_result, 0);
        check("mid_rsp_flags", rsp_flags, 0);
        check("mid_rsp_id", rsp_id, 0);
        check("mid_rsp_err", rsp_err, 0);
        check("mid_cpsr", cpsr_flags, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mid_no_rsp", rsp_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
